// File: rtl/mmio_memory_controller.sv
// eLC-3 memory control unit: SRAM wait-state handshake plus memory-mapped keyboard FIFO and display.
// Optional macro MMIO_TIMER_EN adds a free-running cycle counter at IO_BASE+8.
module mmio_memory_controller #(
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    IO_BASE   = ADDR_W'(16'hFE00),
  parameter int unsigned          SRAM_WAIT = 1,
  parameter int unsigned          KB_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_FromCPU,
  output logic [DATA_W-1:0] Data_ToCPU,
  output logic              Mem_R,
  input  logic [DATA_W-1:0] Data_FromSRAM,
  output logic [DATA_W-1:0] Data_ToSRAM,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_LB,
  output logic              Mem_UB,
  input  logic              Kb_Valid,
  input  logic [7:0]        Kb_Data,
  output logic [DATA_W-1:0] Data_ToVideo,
  output logic              Video_Valid,
  input  logic              Video_Ack,
  output logic              Kb_Int
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] A_KBSR = IO_BASE;
  localparam logic [ADDR_W-1:0] A_KBDR = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_DSR  = IO_BASE + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_DDR  = IO_BASE + ADDR_W'(6);
`ifdef MMIO_TIMER_EN
  localparam logic [ADDR_W-1:0] A_TMR  = IO_BASE + ADDR_W'(8);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rw;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data_to_cpu;
  logic                r_mem_r;
  logic                r_mem_ce;
  logic                r_mem_oe;
  logic                r_mem_we;
  logic                r_sel_kbsr;
  logic                r_sel_kbdr;
  logic                r_sel_ddr;
  logic                r_pop_pend;

  logic [7:0]          r_fifo [KB_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_ie;
  logic                r_ovf;
  logic                r_kb_int;

  logic [DATA_W-1:0]   r_ddr;
  logic                r_video_valid;

  logic                w_sel_kbsr;
  logic                w_sel_kbdr;
  logic                w_sel_dsr;
  logic                w_sel_ddr;
  logic                w_is_io;
  logic                w_kb_nonempty;
  logic                w_kb_full;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_set;
  logic                w_done;
  logic [DATA_W-1:0]   w_io_rdata;

`ifdef MMIO_TIMER_EN
  logic                w_sel_tmr;
  logic                r_sel_tmr;
  logic [DATA_W-1:0]   r_timer;
`endif

  // Address decode: only exact register addresses are I/O, everything else is SRAM
  assign w_sel_kbsr = (Address == A_KBSR);
  assign w_sel_kbdr = (Address == A_KBDR);
  assign w_sel_dsr  = (Address == A_DSR);
  assign w_sel_ddr  = (Address == A_DDR);
`ifdef MMIO_TIMER_EN
  assign w_sel_tmr  = (Address == A_TMR);
  assign w_is_io    = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr | w_sel_tmr;
`else
  assign w_is_io    = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr;
`endif

  assign w_kb_nonempty = (r_level != '0);
  assign w_kb_full     = (r_level == LVL_W'(KB_DEPTH));
  assign w_done        = (r_state == S_DONE);
  // A pop frees a slot in the same cycle, so a simultaneous push into a full FIFO is accepted
  assign w_pop         = w_done & r_pop_pend;
  assign w_push        = Kb_Valid & (~w_kb_full | w_pop);
  assign w_ovf_set     = Kb_Valid & w_kb_full & ~w_pop;

  // I/O read data, captured at request time
  always_comb begin
    w_io_rdata = '0;
    if (w_sel_kbsr) begin
      w_io_rdata[15] = w_kb_nonempty;
      w_io_rdata[14] = r_ie;
      w_io_rdata[0]  = r_ovf;
    end else if (w_sel_kbdr) begin
      w_io_rdata[7:0] = w_kb_nonempty ? r_fifo[r_rd_ptr] : 8'h00;
    end else if (w_sel_dsr) begin
      w_io_rdata[15] = ~r_video_valid;
    end else if (w_sel_ddr) begin
      w_io_rdata = r_ddr;
    end
`ifdef MMIO_TIMER_EN
    else if (w_sel_tmr) begin
      w_io_rdata = r_timer;
    end
`endif
  end

  // Access sequencer: IDLE -> (ACCESS x SRAM_WAIT) -> DONE -> IDLE
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rw          <= 1'b0;
      r_wdata       <= '0;
      r_data_to_cpu <= '0;
      r_mem_r       <= 1'b0;
      r_mem_ce      <= 1'b0;
      r_mem_oe      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_sel_kbsr    <= 1'b0;
      r_sel_kbdr    <= 1'b0;
      r_sel_ddr     <= 1'b0;
      r_pop_pend    <= 1'b0;
`ifdef MMIO_TIMER_EN
      r_sel_tmr     <= 1'b0;
`endif
    end else begin
      r_mem_r <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MIO_EN) begin
            r_rw       <= R_W;
            r_wdata    <= Data_FromCPU;
            r_sel_kbsr <= w_sel_kbsr;
            r_sel_kbdr <= w_sel_kbdr;
            r_sel_ddr  <= w_sel_ddr;
            r_pop_pend <= w_sel_kbdr & ~R_W & w_kb_nonempty;
`ifdef MMIO_TIMER_EN
            r_sel_tmr  <= w_sel_tmr;
`endif
            if (w_is_io) begin
              r_state <= S_DONE;
              r_mem_r <= 1'b1;
              if (!R_W) r_data_to_cpu <= w_io_rdata;
            end else begin
              r_state  <= S_ACCESS;
              r_cnt    <= CNT_W'(SRAM_WAIT - 1);
              r_mem_ce <= 1'b1;
              r_mem_oe <= ~R_W;
              r_mem_we <= R_W;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_mem_r  <= 1'b1;
            r_mem_ce <= 1'b0;
            r_mem_oe <= 1'b0;
            r_mem_we <= 1'b0;
            if (!r_rw) r_data_to_cpu <= Data_FromSRAM;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= Kb_Data;
  end

  // Keyboard FIFO pointers, status bits and interrupt
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ie     <= 1'b0;
      r_ovf    <= 1'b0;
      r_kb_int <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_done && r_rw && r_sel_kbsr) begin
        r_ie  <= r_wdata[14];
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      r_kb_int <= r_ie & w_kb_nonempty;
    end
  end

  // Display channel: a DDR write beats a same-cycle acknowledge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ddr         <= '0;
      r_video_valid <= 1'b0;
    end else if (w_done && r_rw && r_sel_ddr) begin
      r_ddr         <= r_wdata;
      r_video_valid <= 1'b1;
    end else if (Video_Ack && r_video_valid) begin
      r_video_valid <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_timer <= '0;
    end else if (w_done && r_rw && r_sel_tmr) begin
      r_timer <= r_wdata;
    end else begin
      r_timer <= r_timer + DATA_W'(1);
    end
  end
`endif

  assign Data_ToCPU   = r_data_to_cpu;
  assign Mem_R        = r_mem_r;
  assign Data_ToSRAM  = r_wdata;
  assign Mem_CE       = r_mem_ce;
  assign Mem_OE       = r_mem_oe;
  assign Mem_WE       = r_mem_we;
  assign Mem_LB       = 1'b1;
  assign Mem_UB       = 1'b1;
  assign Data_ToVideo = r_ddr;
  assign Video_Valid  = r_video_valid;
  assign Kb_Int       = r_kb_int;

endmodule

// File: tb/tb_mmio_memory_controller.sv
// Scoreboard bench for mmio_memory_controller: directed scenarios plus randomized bus/keyboard/video traffic.
module tb_mmio_memory_controller;

  localparam int          SRAM_WAIT = 3;
  localparam int          KB_DEPTH  = 4;
  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] A_KBSR    = IO_BASE;
  localparam logic [15:0] A_KBDR    = IO_BASE + 16'd2;
  localparam logic [15:0] A_DSR     = IO_BASE + 16'd4;
  localparam logic [15:0] A_DDR     = IO_BASE + 16'd6;
  localparam logic [15:0] A_TMR     = IO_BASE + 16'd8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] Address = 16'h0;
  logic [15:0] Data_FromCPU = 16'h0;
  logic [15:0] Data_ToCPU;
  logic        Mem_R;
  logic [15:0] Data_FromSRAM;
  logic [15:0] Data_ToSRAM;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB;
  logic        Kb_Valid = 1'b0;
  logic [7:0]  Kb_Data = 8'h0;
  logic [15:0] Data_ToVideo;
  logic        Video_Valid;
  logic        Video_Ack = 1'b0;
  logic        Kb_Int;

  mmio_memory_controller #(
    .DATA_W(16), .ADDR_W(16), .IO_BASE(IO_BASE), .SRAM_WAIT(SRAM_WAIT), .KB_DEPTH(KB_DEPTH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .Address(Address),
    .Data_FromCPU(Data_FromCPU), .Data_ToCPU(Data_ToCPU), .Mem_R(Mem_R),
    .Data_FromSRAM(Data_FromSRAM), .Data_ToSRAM(Data_ToSRAM),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_LB(Mem_LB), .Mem_UB(Mem_UB),
    .Kb_Valid(Kb_Valid), .Kb_Data(Kb_Data), .Data_ToVideo(Data_ToVideo),
    .Video_Valid(Video_Valid), .Video_Ack(Video_Ack), .Kb_Int(Kb_Int)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM chip stand-in; undriven reads return a marker value
  bit [15:0] sram_chip [0:65535];
  assign Data_FromSRAM = Mem_OE ? sram_chip[Address] : 16'hDEAD;
  always @(posedge Clk) if (Mem_WE) sram_chip[Address] <= Data_ToSRAM;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the programmer-visible state
  logic [7:0]  m_kq[$];
  bit          m_ie, m_ovf, m_vv;
  logic [15:0] m_ddr;
  logic [15:0] m_mem [logic [15:0]];
  logic [15:0] m_tmr_exp;

  function automatic bit is_io(input logic [15:0] a);
    bit r;
    r = (a == A_KBSR) || (a == A_KBDR) || (a == A_DSR) || (a == A_DDR);
`ifdef MMIO_TIMER_EN
    r = r || (a == A_TMR);
`endif
    return r;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [7:0] k;
    if (a == A_KBSR) return {m_kq.size() != 0, m_ie, 13'b0, m_ovf};
    if (a == A_KBDR) begin
      if (m_kq.size() == 0) return 16'h0;
      k = m_kq.pop_front();
      return {8'h00, k};
    end
    if (a == A_DSR) return {~m_vv, 15'b0};
    if (a == A_DDR) return m_ddr;
`ifdef MMIO_TIMER_EN
    if (a == A_TMR) return m_tmr_exp;
`endif
    return m_mem.exists(a) ? m_mem[a] : 16'h0;
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [15:0] d);
    if (a == A_KBSR) begin m_ie = d[14]; m_ovf = 1'b0; end
    else if (a == A_DDR) begin m_ddr = d; m_vv = 1'b1; end
    else if (!is_io(a)) m_mem[a] = d;
  endfunction

  function automatic void m_push(input logic [7:0] k);
    if (m_kq.size() == KB_DEPTH) m_ovf = 1'b1;
    else m_kq.push_back(k);
  endfunction

  function automatic void m_reset();
    m_kq.delete();
    m_ie = 0; m_ovf = 0; m_vv = 0; m_ddr = 16'h0;
  endfunction

  typedef struct {
    bit          chk;
    logic [15:0] data;
    logic [15:0] addr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int oe_cnt, we_cnt, ce_cnt;

  // Monitor: every Mem_R pulse is matched against the oldest expected response
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (Mem_OE) oe_cnt++;
      if (Mem_WE) we_cnt++;
      if (Mem_CE) ce_cnt++;
      if (Mem_R) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mem_r: got Mem_R=1 with no request outstanding (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("mem_r_latency@%h", e.addr), cyc, e.cyc);
          if (e.chk) check($sformatf("read_data@%h", e.addr), Data_ToCPU, e.data);
        end
      end
    end
  end

  task automatic bus(input bit rw, input logic [15:0] a, input logic [15:0] d,
                     input bit ack_done, input bit kb_done, input logic [7:0] key);
    exp_t e;
    bit   io;
    int   n;
    io = is_io(a);
    @(negedge Clk);
    e.chk  = !rw;
    e.addr = a;
    e.cyc  = cyc + (io ? 1 : SRAM_WAIT + 1);
    e.data = rw ? 16'h0 : m_read(a);
    if (rw) m_write(a, d);
    exp_q.push_back(e);
    oe_cnt = 0; we_cnt = 0; ce_cnt = 0;
    MIO_EN = 1'b1; R_W = rw; Address = a; Data_FromCPU = d;
    @(posedge Clk); #1 MIO_EN = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (!Mem_R && n < 40);
    if (!Mem_R) begin
      n_checks++; n_fail++;
      $display("FAIL bus_timeout@%h: got no Mem_R within 40 cycles, want Mem_R", a);
      exp_q.delete();
    end else begin
      if (ack_done) Video_Ack = 1'b1;
      if (kb_done) begin Kb_Valid = 1'b1; Kb_Data = key; end
      check($sformatf("we_cycles@%h", a), we_cnt, (!io && rw) ? SRAM_WAIT : 0);
      check($sformatf("oe_cycles@%h", a), oe_cnt, (!io && !rw) ? SRAM_WAIT : 0);
      check($sformatf("ce_cycles@%h", a), ce_cnt, io ? 0 : SRAM_WAIT);
      @(posedge Clk); #1;
      Video_Ack = 1'b0; Kb_Valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [15:0] a);
    bus(1'b0, a, 16'h0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus(1'b1, a, d, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic key(input logic [7:0] k);
    @(negedge Clk); Kb_Valid = 1'b1; Kb_Data = k;
    @(posedge Clk); #1 Kb_Valid = 1'b0;
    m_push(k);
  endtask

  task automatic ack();
    @(negedge Clk); Video_Ack = 1'b1;
    @(posedge Clk); #1 Video_Ack = 1'b0;
    if (m_vv) m_vv = 1'b0;
  endtask

  task automatic idle_check();
    repeat (2) @(negedge Clk);
    check("kb_int", Kb_Int, m_ie && (m_kq.size() != 0));
    check("video_valid", Video_Valid, m_vv);
    check("data_to_video", Data_ToVideo, m_ddr);
  endtask

  function automatic logic [15:0] rnd_sram_addr();
    case ($urandom_range(0, 5))
      0: return IO_BASE + 16'd1;
      1: return IO_BASE + 16'd3;
      2: return IO_BASE - 16'd2;
      3: return IO_BASE + 16'h000A;
`ifndef MMIO_TIMER_EN
      4: return A_TMR;
`endif
      default: return 16'h3000 + 16'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    m_reset();
    repeat (3) @(negedge Clk);
    check("rst_mem_r", Mem_R, 0);
    check("rst_ctrl", {Mem_CE, Mem_OE, Mem_WE}, 3'b000);
    check("rst_lb_ub", {Mem_LB, Mem_UB}, 2'b11);
    check("rst_data_to_cpu", Data_ToCPU, 16'h0);
    check("rst_video", {Video_Valid, Kb_Int}, 2'b00);
    check("rst_ddr", Data_ToVideo, 16'h0);
    Reset = 1'b0;

    // SRAM write then read-back through the chip stand-in
    wr(16'h3000, 16'h1234);
    rd(16'h3000);
    rd(A_DSR);

    // Two keys, drained, then an empty read
    key("A"); key("B");
    rd(A_KBSR); rd(A_KBDR); rd(A_KBDR); rd(A_KBSR); rd(A_KBDR);

    // Overflow, in-order read-back, overflow clear, interrupt lag
    for (int i = 0; i < 5; i++) key(8'h61 + 8'(i));
    rd(A_KBSR);
    for (int i = 0; i < 4; i++) rd(A_KBDR);
    wr(A_KBSR, 16'h4000);
    rd(A_KBSR);
    key(8'h5A);
    check("kb_int_lag", Kb_Int, 0);
    @(posedge Clk); #1;
    check("kb_int_after_push", Kb_Int, 1);
    rd(A_KBDR);

    // Full FIFO: pop and push in the same cycle both succeed without overflow
    for (int i = 0; i < 4; i++) key(8'h30 + 8'(i));
    bus(1'b0, A_KBDR, 16'h0, 1'b0, 1'b1, 8'h39);
    m_push(8'h39);
    rd(A_KBSR);
    for (int i = 0; i < 4; i++) rd(A_KBDR);
    wr(A_KBSR, 16'h0000);
    idle_check();

    // Display channel, including write-beats-ack
    wr(A_DDR, 16'h0048);
    check("video_valid_set", Video_Valid, 1);
    check("video_data", Data_ToVideo, 16'h0048);
    rd(A_DSR);
    ack();
    rd(A_DSR);
    check("video_valid_ack", Video_Valid, 0);
    wr(A_DDR, 16'h0055);
    bus(1'b1, A_DDR, 16'h0066, 1'b1, 1'b0, 8'h0);
    rd(A_DSR); rd(A_DDR);
    wr(A_DSR, 16'h0000);
    rd(A_DSR);
    ack();
    idle_check();

    // Reset in the middle of an SRAM access
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b0; Address = 16'h3000;
    @(posedge Clk); #1 MIO_EN = 1'b0;
    @(posedge Clk); #1;
    check("access_oe_before_reset", Mem_OE, 1);
    Reset = 1'b1;
    #1;
    check("reset_drops_ctrl", {Mem_CE, Mem_OE, Mem_WE}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("no_mem_r_in_reset", Mem_R, 0);
    end
    Reset = 1'b0;
    m_reset();
    rd(A_DSR);
    rd(A_KBSR);
    idle_check();

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: begin
          a = rnd_sram_addr();
          wr(a, 16'($urandom));
        end
        3, 4:  rd(rnd_sram_addr());
        5, 6:  key(8'($urandom_range(32, 126)));
        7:     rd(A_KBDR);
        8:     rd(A_KBSR);
        9:     wr(A_KBSR, 16'($urandom));
        10: begin
          case ($urandom_range(0, 3))
            0: wr(A_DDR, 16'($urandom));
            1: rd(A_DSR);
            2: rd(A_DDR);
            default: wr(A_DSR, 16'($urandom));
          endcase
        end
        default: ack();
      endcase
      idle_check();
    end

`ifdef MMIO_TIMER_EN
    // Counter load near all-ones, then read after it has wrapped
    wr(A_TMR, 16'hFFFE);
    repeat (5) @(negedge Clk);
    m_tmr_exp = 16'h0003;
    rd(A_TMR);
`endif

    repeat (4) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL outstanding_responses: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_memory_controller.md
Name: mmio_memory_controller

Overview:
- Parametrised memory control unit that sits between the eLC-3 CPU memory interface and the SRAM chip.
- Adds a CPU ready handshake with configurable SRAM wait states.
- Adds a buffered keyboard input channel (KBSR/KBDR with FIFO) and a handshaked display channel (DSR/DDR).
- Generates a keyboard interrupt request.

Parameters:
DATA_W, 16, width of CPU/SRAM/device data
ADDR_W, 16, width of CPU address
IO_BASE, 16'hFE00, base of the memory-mapped I/O window; KBSR=+0, KBDR=+2, DSR=+4, DDR=+6
SRAM_WAIT, 1, cycles Mem_OE/Mem_WE are held before ready (legal range 1..15)
KB_DEPTH, 4, keyboard FIFO entries (power of 2, at least 2)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
MIO_EN  in  1  CPU memory request; sampled in IDLE
R_W  in  1  1 = write, 0 = read
Address  in  ADDR_W  CPU address
Data_FromCPU  in  DATA_W  write data
Data_ToCPU  out  DATA_W  read data; valid while Mem_R=1
Mem_R  out  1  one-cycle ready pulse ending an access
Data_FromSRAM  in  DATA_W  SRAM read bus
Data_ToSRAM  out  DATA_W  SRAM write bus (= Data_FromCPU)
Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB  out  1 each  active-high SRAM controls
Kb_Valid  in  1  keyboard byte strobe, one cycle
Kb_Data  in  8  keyboard character
Data_ToVideo  out  DATA_W  last DDR value
Video_Valid  out  1  DDR written, character pending
Video_Ack  in  1  video consumed the character
Kb_Int  out  1  keyboard interrupt request

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; FIFO empty; KBSR[14] (IE) = 0; overflow flag = 0.
  - DSR[15] = 1; DDR = 0; Video_Valid = 0; Mem_R = 0.
  - Mem_OE = 0, Mem_WE = 0, Mem_CE = 0, Data_ToCPU = 0.
- Mem_LB = Mem_UB = 1 always. Mem_CE = 1 in ACCESS only.
- FSM IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: on MIO_EN=1, latch Address, R_W and data, and decode.
    - I/O address: go directly to DONE (1-cycle latency).
    - Otherwise: go to ACCESS and load the wait counter with SRAM_WAIT-1.
  - ACCESS: Mem_OE=!R_W, Mem_WE=R_W; decrement the counter; go to DONE at 0. Read data is captured from Data_FromSRAM on the last ACCESS cycle.
  - DONE: Mem_R=1 for exactly 1 cycle; Data_ToCPU holds the captured value; register side effects commit here; then IDLE.
  - A request still held on MIO_EN in IDLE after DONE starts a new access.
- Latency: SRAM access = SRAM_WAIT+1 cycles from the MIO_EN sample to Mem_R; I/O access = 1 cycle.
- Decode: only the exact addresses IO_BASE+0/2/4/6 (plus +8 with the optional feature) are I/O; all other addresses are SRAM.
- KBSR read: {nonempty, IE, 13'b0, ovf} (zero-extended to DATA_W).
- KBSR write: IE = data[14]; ovf cleared.
- KBDR read: {zeros, FIFO head}; pops the FIFO in DONE. Reading while empty returns 0 and does not pop.
- FIFO push on Kb_Valid:
  - When full: byte dropped, ovf=1 (sticky).
  - Push and pop in the same cycle while full: both succeed; ovf is not set.
- DSR read: {DSR[15], zeros}. DSR writes are ignored.
- DDR write: DDR=data, DSR[15]=0, Video_Valid=1.
- Video_Ack (while Video_Valid=1): Video_Valid=0, DSR[15]=1. If an Ack and a new DDR write land in the same cycle, the write wins (Valid stays 1, DSR[15]=0).
- DDR read returns DDR.
- Kb_Int = IE & nonempty, registered (1-cycle delay).
- Reset mid-access: access aborted; no Mem_R; SRAM controls drop immediately.

Optional Feature:
- Macro MMIO_TIMER_EN.
- Defined:
  - Adds a free-running DATA_W-bit cycle counter at IO_BASE+8, reset to 0, wrapping at all-ones.
  - Read returns the counter value; a write loads the counter with Data_FromCPU (the write takes effect in DONE; counting resumes from the loaded value).
- Undefined: IO_BASE+8 decodes as ordinary SRAM.

Test Plan:
- SRAM_WAIT=3, write 16'h1234 to 16'h3000 -> Mem_WE=1 for 3 cycles, Mem_R on the 4th cycle; a later read of 16'h3000 with SRAM returning 16'h1234 gives Data_ToCPU=16'h1234 with Mem_R.
- Push keys 'A','B'; read KBSR -> 16'h8000; read KBDR twice -> 16'h0041, 16'h0042; then KBSR -> 16'h0000; a third KBDR read -> 0.
- KB_DEPTH=4, push 5 keys -> KBSR=16'h8001; first 4 keys are read back in order; write KBSR=16'h4000 -> ovf clears; Kb_Int=1 one cycle after the next push.
- Write DDR=16'h0048 -> Video_Valid=1, DSR=16'h0000, Data_ToVideo=16'h0048; pulse Video_Ack -> DSR=16'h8000, Valid=0.
- Assert Reset during ACCESS -> Mem_OE/Mem_WE/Mem_CE=0 at once; no Mem_R; DSR=16'h8000 after release.
- MMIO_TIMER_EN defined: write 16'hFFFE to IO_BASE+8, wait, read -> the value has wrapped past 16'h0000.
